// File: rtl/seq_detect_arbiter_pkg.sv
// rtl/seq_detect_arbiter_pkg.sv - shared encodings and defaults for the sequence-detect arbiter
package seq_detect_arbiter_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;
  localparam int HIT_W    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    DET_A = 2'b00,
    DET_B = 2'b01,
    DET_C = 2'b10,
    DET_D = 2'b11
  } det_state_t;

  function automatic det_state_t det_next(input det_state_t s, input logic b);
    case (s)
      DET_A:   det_next = b ? DET_B : DET_A;
      DET_B:   det_next = b ? DET_B : DET_C;
      DET_C:   det_next = b ? DET_D : DET_C;
      default: det_next = b ? DET_A : DET_D;
    endcase
  endfunction

endpackage

// File: rtl/seq_detect_arbiter_if.sv
// rtl/seq_detect_arbiter_if.sv - requester/result bundle between requesters and the arbiter
interface seq_detect_arbiter_if
  import seq_detect_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] data_i;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              done;
  logic [IDW-1:0]    done_id;
  logic [HIT_W-1:0]  hit_cnt;

  modport master (output req, data_i, input gnt, busy, done, done_id, hit_cnt);
  modport slave  (input req, data_i, output gnt, busy, done, done_id, hit_cnt);
endinterface

// File: rtl/seq_det_core.sv
// rtl/seq_det_core.sv - Moore pattern detector; hit pulses on the C->D step
module seq_det_core
  import seq_detect_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       bit_in,
  input  logic       en,
  output det_state_t state,
  output logic       hit
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DET_A;
    end else if (clr) begin
      state <= DET_A;
    end else if (en) begin
      state <= det_next(state, bit_in);
    end
  end

  assign hit = en && (state == DET_C) && bit_in;

endmodule

// File: rtl/seq_detect_arbiter.sv
// rtl/seq_detect_arbiter.sv - round-robin arbiter feeding one captured word at a time
// through the pattern detector and reporting the hit count per requester.
module seq_detect_arbiter
  import seq_detect_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_detect_arbiter_if.slave  bus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(W + 1);

  ctrl_state_t      state, state_nxt;
  logic [IDW-1:0]   ptr, winner, cur_id, rr_idx;
  logic [W-1:0]     shreg;
  logic [CW-1:0]    bit_cnt;
  logic [HIT_W-1:0] hits;
  logic             take, shift_en, report, det_hit;
  det_state_t       det_state_unused;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|bus.req) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == CW'(W - 1)) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    take     = (state == IDLE) && (|bus.req);
    shift_en = (state == SHIFT);
    report   = (state == REPORT);
  end

  // Walk offsets downward so the smallest offset from ptr is the last one to claim the win.
  always_comb begin
    winner = '0;
    rr_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      rr_idx = IDW'((int'(ptr) + i) % NREQ);
      if (bus.req[rr_idx]) winner = rr_idx;
    end
  end

  seq_det_core u_core (
    .clk    (clk),
    .reset  (reset),
    .clr    (take),
    .bit_in (shreg[W-1]),
    .en     (shift_en),
    .state  (det_state_unused),
    .hit    (det_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr         <= '0;
      cur_id      <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      hits        <= '0;
      bus.gnt     <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.done_id <= '0;
      bus.hit_cnt <= '0;
    end else begin
      bus.gnt  <= '0;
      bus.done <= 1'b0;
      if (take) begin
        bus.gnt  <= NREQ'(1) << winner;
        bus.busy <= 1'b1;
        cur_id   <= winner;
        ptr      <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
        shreg    <= bus.data_i[int'(winner)*W +: W];
        bit_cnt  <= '0;
        hits     <= '0;
      end else if (state == IDLE) begin
        bus.busy <= 1'b0;
      end
      if (shift_en) begin
        shreg   <= {shreg[W-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
        if (det_hit && hits != '1) hits <= hits + 1'b1;
      end
      // done is registered off REPORT, so busy stays up through the done cycle.
      if (report) begin
        bus.done    <= 1'b1;
        bus.done_id <= cur_id;
        bus.hit_cnt <= hits;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// tb/tb_seq_detect_arbiter.sv - randomized and directed bench for seq_detect_arbiter
module tb_seq_detect_arbiter;
  import seq_detect_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  seq_detect_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(2)) bus ();

  seq_detect_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  bit         m_busy;
  int         m_k, m_ptr, m_id, m_hits;
  logic [3:0] exp_gnt;
  bit         exp_done, exp_busy;

  int cyc = 0;
  int obs_gnt_q[$];
  int obs_gnt_cyc[$];
  int obs_done_cyc[$];
  int obs_id, obs_hits;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pattern is 1, 0, 1, 1 where a non-matching bit simply waits in place.
  function automatic int ref_hits(input logic [W-1:0] word);
    int  phase = 0;
    int  h = 0;
    bit  want;
    for (int i = W - 1; i >= 0; i--) begin
      want = (phase != 1);
      if (word[i] == want) begin
        if (phase == 2) h++;
        phase = (phase + 1) % 4;
      end
    end
    return (h > 15) ? 15 : h;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int i = p; i < NREQ; i++) if (r[i]) return i;
    for (int i = 0; i < p; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_k = 0; m_ptr = 0; m_id = 0; m_hits = 0;
    exp_gnt = '0; exp_done = 0; exp_busy = 0;
  endtask

  task automatic clear_logs();
    obs_gnt_q.delete(); obs_gnt_cyc.delete(); obs_done_cyc.delete();
    obs_id = -1; obs_hits = -1;
  endtask

  task automatic step();
    int w;
    @(posedge clk);
    #1;
    cyc++;
    exp_gnt  = '0;
    exp_done = 0;
    if (reset) begin
      model_reset();
    end else begin
      if (m_busy && m_k == W + 1) m_busy = 0;
      if (m_busy) begin
        m_k++;
        if (m_k == W + 1) exp_done = 1;
      end else begin
        w = rr_pick(bus.req, m_ptr);
        if (w >= 0) begin
          m_busy  = 1;
          m_k     = 0;
          m_id    = w;
          m_hits  = ref_hits(bus.data_i[w*W +: W]);
          m_ptr   = (w + 1) % NREQ;
          exp_gnt = 4'(1 << w);
        end
      end
    end
    exp_busy = m_busy;
    chk("gnt", bus.gnt, exp_gnt);
    chk("busy", bus.busy, exp_busy);
    chk("done", bus.done, exp_done);
    if (exp_done) begin
      chk("done_id", bus.done_id, m_id);
      chk("hit_cnt", bus.hit_cnt, m_hits);
    end
    if (bus.gnt != 0) begin
      obs_gnt_q.push_back(int'(bus.gnt));
      obs_gnt_cyc.push_back(cyc);
    end
    if (bus.done) begin
      obs_done_cyc.push_back(cyc);
      obs_id   = int'(bus.done_id);
      obs_hits = int'(bus.hit_cnt);
    end
    bus.req = bus.req & ~exp_gnt;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
    model_reset();
    run(2);
    reset = 1'b0;
  endtask

  initial begin
    bus.req    = '0;
    bus.data_i = '0;
    model_reset();
    run(3);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_done_id", bus.done_id, 0);
    chk("rst_hit_cnt", bus.hit_cnt, 0);
    reset = 1'b0;

    clear_logs();
    bus.data_i[0*W +: W] = 8'b1011_0000;
    bus.req = 4'b0001;
    run(12);
    chk("r027_gnt", obs_gnt_q.size() > 0 ? obs_gnt_q[0] : -1, 1);
    chk("r027_lat", obs_done_cyc.size() > 0 && obs_gnt_cyc.size() > 0 ?
        obs_done_cyc[0] - obs_gnt_cyc[0] : -1, 9);
    chk("r027_id", obs_id, 0);
    chk("r027_hits", obs_hits, 1);

    clear_logs();
    bus.data_i[2*W +: W] = 8'b1011_0101;
    bus.req = 4'b0100;
    run(12);
    chk("r028_id", obs_id, 2);
    chk("r028_hits", obs_hits, 2);
    clear_logs();
    bus.data_i[2*W +: W] = 8'h00;
    bus.req = 4'b0100;
    run(12);
    chk("r028_zero_hits", obs_hits, 0);

    do_reset();
    clear_logs();
    bus.data_i = $urandom;
    bus.req = 4'b1111;
    run(45);
    chk("r029_count", obs_gnt_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_gnt_q.size(); i++) begin
      chk("r029_order", obs_gnt_q[i], 1 << i);
      if (i > 0) chk("r029_gap", obs_gnt_cyc[i] - obs_gnt_cyc[i-1], 10);
    end

    do_reset();
    clear_logs();
    bus.req = 4'b0001;
    run(2);
    bus.req = 4'b1001;
    run(25);
    chk("r030_second", obs_gnt_q.size() > 1 ? obs_gnt_q[1] : -1, 4'b1000);

    do_reset();
    clear_logs();
    bus.data_i[0*W +: W] = 8'b1011_0101;
    bus.req = 4'b0001;
    run(4);
    #1;
    reset = 1'b1;
    #1;
    chk("r031_gnt", bus.gnt, 0);
    chk("r031_busy", bus.busy, 0);
    chk("r031_done", bus.done, 0);
    chk("r031_done_id", bus.done_id, 0);
    chk("r031_hit_cnt", bus.hit_cnt, 0);
    model_reset();
    run(2);
    reset = 1'b0;
    run(12);
    chk("r031_no_done", obs_done_cyc.size(), 0);
    clear_logs();
    bus.req = 4'b0001;
    run(12);
    chk("r031_redo_id", obs_id, 0);
    chk("r031_redo_hits", obs_hits, 2);

    do_reset();
    clear_logs();
    bus.req = 4'b0001;
    run(3);
    bus.req = 4'b0010;
    run(3);
    bus.req = 4'b0000;
    run(12);
    chk("r032_grants", obs_gnt_q.size(), 1);

    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.data_i = $urandom;
      for (int k = 0; k < NREQ; k++) begin
        if (!bus.req[k] && $urandom_range(0, 7) == 0) bus.req[k] = 1'b1;
        else if (bus.req[k] && $urandom_range(0, 31) == 0) bus.req[k] = 1'b0;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_arbiter.md
SEQ_DETECT_ARBITER -- requirements
Module: seq_detect_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing the detector.
REQ-002 Parameter: W, 8, bits per request word.
REQ-003 Port: clk  in  1  single clock for all state; rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: req  in  NREQ  per-requester request level; held high until granted.
REQ-006 Port: data_i  in  NREQ*W  requester k word in bits [k*W +: W].
REQ-007 Port: gnt  out  NREQ  one-hot grant, one-cycle pulse when the word is captured.
REQ-008 Port: busy  out  1  high from grant cycle until done cycle inclusive.
REQ-009 Port: done  out  1  one-cycle result-valid pulse.
REQ-010 Port: done_id  out  2  index of the requester the result belongs to; valid with done.
REQ-011 Port: hit_cnt  out  4  number of pattern matches in the word; valid with done.

Function
REQ-012 Control FSM SHALL have states IDLE, SHIFT and REPORT.
REQ-013 IDLE with req!=0 at a clock edge SHALL: select the winner round-robin starting at pointer ptr; register a one-hot gnt; capture that requester's data_i into a W-bit shift register; clear the bit counter, hit counter and detector core to state A; go to SHIFT.
REQ-014 IDLE with req==0 SHALL hold all state, with gnt=0 and done=0.
REQ-015 Round-robin: ptr SHALL become (winner+1) mod NREQ after each grant, so the lowest index at or above ptr with req high wins.
REQ-016 SHIFT SHALL feed one bit per cycle, MSB first, into the detector core for exactly W cycles, then go to REPORT.
REQ-017 Detector core SHALL be a Moore machine: A-1->B, A-0->A; B-0->C, B-1->B; C-1->D, C-0->C; D-1->A, D-0->D.
REQ-018 Each C->D transition during SHIFT SHALL increment the hit counter; the counter saturates at 15.
REQ-019 REPORT SHALL last one cycle with done=1 and the captured done_id and hit_cnt, then return to IDLE.
REQ-020 Latency: done SHALL rise exactly W+1 cycles after gnt rises; the next grant occurs no earlier than the cycle after done.
REQ-021 req changes while busy SHALL be ignored until IDLE; a req dropped before grant is withdrawn and is not granted.
REQ-022 done_id and hit_cnt SHALL hold their last values outside done; the bench checks them only when done=1.

Reset
REQ-023 Reset SHALL act asynchronously: FSM to IDLE, core to A, ptr=0, and shift register, counters, gnt, busy, done, done_id and hit_cnt all 0.
REQ-024 Reset during SHIFT or REPORT SHALL abort the word with no done pulse; the aborted requester must re-request.

Structure
REQ-025 A shared package SHALL hold the control-state encoding (IDLE/SHIFT/REPORT), the detector-state encoding (A=00, B=01, C=10, D=11), and defaults for NREQ and W.
REQ-026 The detector core SHALL be a sub-module seq_det_core (clk, reset, sync clear, bit in, enable, state out, hit pulse out).

Verification
REQ-027 After reset, req=0001 with word0=8'b10110000: gnt=0001 for one cycle; 9 cycles later done=1, done_id=0, hit_cnt=1.
REQ-028 req=0100 with word2=8'b10110101: done_id=2, hit_cnt=2; word 8'h00 gives hit_cnt=0.
REQ-029 req=1111 held, each requester dropping req after its grant: grants in order 0001, 0010, 0100, 1000, each 10 cycles apart.
REQ-030 Requester 0 granted, req=0001 reasserted alongside req=1000: the next grant is 1000 (pointer fairness).
REQ-031 Reset asserted in the 4th SHIFT cycle: all outputs go to 0 immediately with no done; re-request gives correct results.
REQ-032 req pulsed while busy, then dropped before IDLE: no grant is issued.
